// File: rtl/l1_private_cache.sv
// Single-line private L1 cache with a MESI line, a four-state miss/writeback FSM,
// and a snoop responder that services directory forwards in any state.
`ifndef L1_CACHE_DEFS
`define L1_CACHE_DEFS
`define TAG_WIDTH 8
`define DATA_WIDTH 8
`define MSG_WIDTH 4
`define MESI_WIDTH 2
`define OWNER_BITS 2
`define DIR_WIDTH 4
`define MESI_I 2'd0
`define MESI_S 2'd1
`define MESI_E 2'd2
`define MESI_M 2'd3
`define MSG_TYPE_NONE 4'd0
`define MSG_TYPE_LOAD_REQ 4'd1
`define MSG_TYPE_STORE_REQ 4'd2
`define MSG_TYPE_WB_REQ 4'd3
`define MSG_TYPE_DATA_ACK 4'd4
`define MSG_TYPE_LOAD_FWD 4'd5
`define MSG_TYPE_STORE_FWD 4'd6
`define MSG_TYPE_INV_FWD 4'd7
`define MSG_TYPE_LOAD_FWDACK 4'd8
`define MSG_TYPE_STORE_FWDACK 4'd9
`define MSG_TYPE_INV_FWDACK 4'd10
`endif

module l1_private_cache #(
  parameter int CORE_ID = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_req_valid,
  input  logic                     core_req_we,
  input  logic [`TAG_WIDTH-1:0]    core_req_tag,
  input  logic [`DATA_WIDTH-1:0]   core_req_data,
  output logic                     core_busy,
  output logic                     core_resp_valid,
  output logic [`DATA_WIDTH-1:0]   core_resp_data,
  input  logic [`MSG_WIDTH-1:0]    msg2_type,
  input  logic [`DATA_WIDTH-1:0]   msg2_data,
  input  logic [`TAG_WIDTH-1:0]    msg2_tag,
  input  logic [`TAG_WIDTH-1:0]    msg2_load_tag,
  input  logic [`MESI_WIDTH-1:0]   mesi_send,
  input  logic [`OWNER_BITS-1:0]   cache_owner,
  input  logic [`DIR_WIDTH-1:0]    share_list,
  output logic [`MSG_WIDTH-1:0]    msg1_type,
  output logic [`DATA_WIDTH-1:0]   msg1_data,
  output logic [`TAG_WIDTH-1:0]    msg1_tag,
  output logic [`OWNER_BITS-1:0]   msg1_source,
  output logic [`MSG_WIDTH-1:0]    msg3_type,
  output logic [`DATA_WIDTH-1:0]   msg3_data,
  output logic [`TAG_WIDTH-1:0]    msg3_tag,
  output logic [`OWNER_BITS-1:0]   msg3_source
);

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, REQ = 2'd2, WAIT_ACK = 2'd3} state_t;

  localparam logic [`OWNER_BITS-1:0] OWNER_ID = `OWNER_BITS'(CORE_ID);

  state_t                  state_r, state_nx;
  logic [`MESI_WIDTH-1:0]  line_state_r, line_state_nx;
  logic [`TAG_WIDTH-1:0]   line_tag_r, line_tag_nx;
  logic [`DATA_WIDTH-1:0]  line_data_r, line_data_nx;
  logic                    req_we_r, req_we_nx;
  logic [`TAG_WIDTH-1:0]   req_tag_r, req_tag_nx;
  logic [`DATA_WIDTH-1:0]  req_data_r, req_data_nx;
  logic                    armed_r, armed_nx;

  logic                    resp_valid_nx;
  logic [`DATA_WIDTH-1:0]  resp_data_nx;
  logic [`MSG_WIDTH-1:0]   msg1_type_nx, msg3_type_nx;
  logic [`DATA_WIDTH-1:0]  msg1_data_nx, msg3_data_nx;
  logic [`TAG_WIDTH-1:0]   msg1_tag_nx, msg3_tag_nx;
  logic [`OWNER_BITS-1:0]  msg1_source_nx, msg3_source_nx;

  logic snoop_load_s, snoop_store_s, snoop_inv_s, snoop_fire_s, is_fwd_s;
  logic hit_s, ack_match_s, unused_s;

  assign snoop_load_s  = (msg2_type == `MSG_TYPE_LOAD_FWD) && (cache_owner == OWNER_ID);
  assign snoop_store_s = (msg2_type == `MSG_TYPE_STORE_FWD) && (cache_owner == OWNER_ID);
  assign snoop_inv_s   = (msg2_type == `MSG_TYPE_INV_FWD) && share_list[CORE_ID];
  assign snoop_fire_s  = armed_r && (snoop_load_s || snoop_store_s || snoop_inv_s);
  assign is_fwd_s      = (msg2_type == `MSG_TYPE_LOAD_FWD) || (msg2_type == `MSG_TYPE_STORE_FWD) ||
                         (msg2_type == `MSG_TYPE_INV_FWD);
  assign hit_s         = (line_state_r != `MESI_I) && (line_tag_r == core_req_tag);
  assign ack_match_s   = (msg2_type == `MSG_TYPE_DATA_ACK) && (msg2_tag == req_tag_r) &&
                         (cache_owner == OWNER_ID);
  // A snoop cycle blocks the core so a hit cannot race the line update.
  assign core_busy     = (state_r != IDLE) || snoop_fire_s;
  assign unused_s      = ^msg2_load_tag;

  // Next-state, line update and next registered output values.
  always_comb begin
    state_nx       = state_r;
    line_state_nx  = line_state_r;
    line_tag_nx    = line_tag_r;
    line_data_nx   = line_data_r;
    req_we_nx      = req_we_r;
    req_tag_nx     = req_tag_r;
    req_data_nx    = req_data_r;
    armed_nx       = armed_r;
    resp_valid_nx  = 1'b0;
    resp_data_nx   = '0;
    msg1_type_nx   = `MSG_TYPE_NONE;
    msg1_data_nx   = '0;
    msg1_tag_nx    = '0;
    msg1_source_nx = '0;
    msg3_type_nx   = `MSG_TYPE_NONE;
    msg3_data_nx   = '0;
    msg3_tag_nx    = '0;
    msg3_source_nx = '0;

    if (snoop_fire_s) begin
      armed_nx       = 1'b0;
      msg3_data_nx   = line_data_r;
      msg3_tag_nx    = line_tag_r;
      msg3_source_nx = OWNER_ID;
      if (snoop_load_s) begin
        msg3_type_nx  = `MSG_TYPE_LOAD_FWDACK;
        line_state_nx = `MESI_S;
      end else if (snoop_store_s) begin
        msg3_type_nx  = `MSG_TYPE_STORE_FWDACK;
        line_state_nx = `MESI_I;
      end else begin
        msg3_type_nx  = `MSG_TYPE_INV_FWDACK;
        line_state_nx = `MESI_I;
      end
    end else if (!is_fwd_s || ((msg2_type == `MSG_TYPE_INV_FWD) && !share_list[CORE_ID])) begin
      armed_nx = 1'b1;
    end else begin
      armed_nx = armed_r;
    end

    case (state_r)
      IDLE: begin
        if (core_req_valid && !snoop_fire_s) begin
          if (hit_s && !core_req_we) begin
            resp_valid_nx = 1'b1;
            resp_data_nx  = line_data_r;
          end else if (hit_s && core_req_we &&
                       ((line_state_r == `MESI_M) || (line_state_r == `MESI_E))) begin
            line_data_nx  = core_req_data;
            line_state_nx = `MESI_M;
            resp_valid_nx = 1'b1;
            resp_data_nx  = core_req_data;
          end else begin
            req_we_nx   = core_req_we;
            req_tag_nx  = core_req_tag;
            req_data_nx = core_req_data;
            if ((line_state_r == `MESI_M) && (line_tag_r != core_req_tag)) begin
              state_nx = WB;
            end else begin
              state_nx = REQ;
            end
          end
        end else begin
          state_nx = IDLE;
        end
      end
      WB: begin
        // A concurrent snoop owns msg3 this cycle; an invalidating one makes the WB moot.
        if (snoop_fire_s) begin
          if (snoop_store_s || snoop_inv_s) begin
            state_nx = REQ;
          end else begin
            state_nx = WB;
          end
        end else begin
          msg3_type_nx   = `MSG_TYPE_WB_REQ;
          msg3_data_nx   = line_data_r;
          msg3_tag_nx    = line_tag_r;
          msg3_source_nx = OWNER_ID;
          line_state_nx  = `MESI_I;
          state_nx       = REQ;
        end
      end
      REQ: begin
        msg1_type_nx   = req_we_r ? `MSG_TYPE_STORE_REQ : `MSG_TYPE_LOAD_REQ;
        msg1_data_nx   = req_data_r;
        msg1_tag_nx    = req_tag_r;
        msg1_source_nx = OWNER_ID;
        state_nx       = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_match_s) begin
          line_tag_nx   = req_tag_r;
          resp_valid_nx = 1'b1;
          if (req_we_r) begin
            line_data_nx  = req_data_r;
            line_state_nx = `MESI_M;
            resp_data_nx  = req_data_r;
          end else begin
            line_data_nx  = msg2_data;
            line_state_nx = mesi_send;
            resp_data_nx  = msg2_data;
          end
          state_nx = IDLE;
        end else begin
          state_nx = WAIT_ACK;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Line, latched request, snoop arm and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_state_r    <= `MESI_I;
      line_tag_r      <= '0;
      line_data_r     <= '0;
      req_we_r        <= 1'b0;
      req_tag_r       <= '0;
      req_data_r      <= '0;
      armed_r         <= 1'b1;
      core_resp_valid <= 1'b0;
      core_resp_data  <= '0;
      msg1_type       <= '0;
      msg1_data       <= '0;
      msg1_tag        <= '0;
      msg1_source     <= '0;
      msg3_type       <= '0;
      msg3_data       <= '0;
      msg3_tag        <= '0;
      msg3_source     <= '0;
    end else begin
      line_state_r    <= line_state_nx;
      line_tag_r      <= line_tag_nx;
      line_data_r     <= line_data_nx;
      req_we_r        <= req_we_nx;
      req_tag_r       <= req_tag_nx;
      req_data_r      <= req_data_nx;
      armed_r         <= armed_nx;
      core_resp_valid <= resp_valid_nx;
      core_resp_data  <= resp_data_nx;
      msg1_type       <= msg1_type_nx;
      msg1_data       <= msg1_data_nx;
      msg1_tag        <= msg1_tag_nx;
      msg1_source     <= msg1_source_nx;
      msg3_type       <= msg3_type_nx;
      msg3_data       <= msg3_data_nx;
      msg3_tag        <= msg3_tag_nx;
      msg3_source     <= msg3_source_nx;
    end
  end

endmodule
